// File: rtl/sam_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sam_bus_pkg
// Description : Shared types and constants for the SAM memory bus master.
//               FSM state encoding, Rw polarity and default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package sam_bus_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR      = 3'd3,
      ERR     = 3'd4
   } state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MEM_DEPTH = 64;

endpackage : sam_bus_pkg
`default_nettype wire

// File: rtl/sam_bus_tristate.sv
`default_nettype none
// ============================================================================
// Module      : sam_bus_tristate
// Description : Registered tri-state driver for the shared Data_Bus.
//               The output enable and data are registered so the bus is
//               driven glitch-free for exactly the cycles the enable is high.
// Ports       : clk      - system clock
//               rst      - asynchronous active-low reset (releases the bus)
//               i_oe     - next-cycle output enable
//               i_data   - next-cycle drive data
//               o_bus_in - resolved bus value as seen on the pins
//               io_bus   - bidirectional data bus
// Revision    : 1.0 - initial release
// ============================================================================
module sam_bus_tristate #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_oe,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_bus_in,
   inout  wire  [DATA_W-1:0] io_bus
);

   logic              r_oe;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_oe   <= 1'b0;
         r_data <= '0;
      end else begin
         r_oe   <= i_oe;
         r_data <= i_data;
      end
   end

   assign io_bus   = r_oe ? r_data : {DATA_W{1'bz}};
   // Passed straight through so X/Z on the bus reaches the read path as-is.
   assign o_bus_in = io_bus;

endmodule : sam_bus_tristate
`default_nettype wire

// File: rtl/sam_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : sam_mem_bus_master
// Description : Initiator for the SAM memory interface (En/Rw/Address_Bus/
//               Data_Bus). Turns valid/ready requests into timed read and
//               write cycles and returns a one-cycle response pulse.
//               Out-of-range addresses are rejected without a bus cycle.
// Ports       : clk, rst            - clock, asynchronous active-low reset
//               req_valid/req_ready - request handshake
//               req_write/req_addr/req_wdata - request payload
//               pause               - hold off new requests while idle
//               rsp_valid/rsp_err/rsp_rdata - response (one-cycle pulse)
//               En/Rw/Address_Bus   - registered memory control
//               Data_Bus            - driven only during WR, else high-Z
// Revision    : 1.0 - initial release
// ============================================================================
module sam_mem_bus_master
   import sam_bus_pkg::*;
#(
   parameter int          ADDR_W    = DEF_ADDR_W,
   parameter int          DATA_W    = DEF_DATA_W,
   parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              pause,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              En,
   output logic              Rw,
   output logic [ADDR_W-1:0] Address_Bus,
   inout  wire  [DATA_W-1:0] Data_Bus
);

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_en;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic              w_en_nxt;
   logic              w_rw_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_rsp_valid_nxt;
   logic              w_rsp_err_nxt;
   logic [DATA_W-1:0] w_rsp_rdata_nxt;
   logic              w_oe_nxt;
   logic [DATA_W-1:0] w_wdata_nxt;
   logic [DATA_W-1:0] w_bus_in;
   logic              w_accept;
   logic              w_in_range;

   // Ready is deliberately combinational so a new request can be taken in
   // the same cycle the previous response is being presented.
   assign req_ready  = (r_state == IDLE) && !pause && rst;
   assign w_accept   = req_valid && req_ready;
   assign w_in_range = (32'(req_addr) < MEM_DEPTH);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_en_nxt        = r_en;
      w_rw_nxt        = r_rw;
      w_addr_nxt      = r_addr;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_oe_nxt        = 1'b0;
      w_wdata_nxt     = '0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (!w_in_range) begin
                  w_state_nxt = ERR;
               end else if (req_write) begin
                  w_state_nxt = WR;
                  w_en_nxt    = 1'b1;
                  w_rw_nxt    = RW_WRITE;
                  w_addr_nxt  = req_addr;
                  w_oe_nxt    = 1'b1;
                  w_wdata_nxt = req_wdata;
               end else begin
                  w_state_nxt = RD_REQ;
                  w_en_nxt    = 1'b1;
                  w_rw_nxt    = RW_READ;
                  w_addr_nxt  = req_addr;
               end
            end
         end
         RD_REQ: begin
            // Memory captures the request on the edge leaving this state.
            w_state_nxt = RD_WAIT;
            w_en_nxt    = 1'b0;
         end
         RD_WAIT: begin
            // Read data is valid on the bus throughout this cycle.
            w_state_nxt     = IDLE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = w_bus_in;
         end
         WR: begin
            w_state_nxt     = IDLE;
            w_en_nxt        = 1'b0;
            w_rw_nxt        = RW_READ;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = '0;
         end
         ERR: begin
            w_state_nxt     = IDLE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_en_nxt    = 1'b0;
            w_rw_nxt    = RW_READ;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registered bus and response outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_en        <= 1'b0;
         r_rw        <= RW_READ;
         r_addr      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_en        <= w_en_nxt;
         r_rw        <= w_rw_nxt;
         r_addr      <= w_addr_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
      end
   end

   // Output enable is only set on the transition into WR, so the bus is
   // driven for exactly the WR cycle.
   sam_bus_tristate #(
      .DATA_W (DATA_W)
   ) u_tristate (
      .clk      (clk),
      .rst      (rst),
      .i_oe     (w_oe_nxt),
      .i_data   (w_wdata_nxt),
      .o_bus_in (w_bus_in),
      .io_bus   (Data_Bus)
   );

   assign En          = r_en;
   assign Rw          = r_rw;
   assign Address_Bus = r_addr;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_err     = r_rsp_err;
   assign rsp_rdata   = r_rsp_rdata;

endmodule : sam_mem_bus_master
`default_nettype wire

// File: tb/tb_sam_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sam_mem_bus_master
// Description : Scoreboard testbench for sam_mem_bus_master with a bus-side
//               memory model and a reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sam_mem_bus_master;

   localparam int DEPTH = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [7:0] req_addr  = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       pause     = 1'b0;
   wire        req_ready;
   wire        rsp_valid;
   wire        rsp_err;
   wire  [7:0] rsp_rdata;
   wire        En;
   wire        Rw;
   wire  [7:0] Address_Bus;
   wire  [7:0] Data_Bus;

   always #5 clk = ~clk;

   sam_mem_bus_master #(
      .ADDR_W    (8),
      .DATA_W    (8),
      .MEM_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .pause       (pause),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .rsp_rdata   (rsp_rdata),
      .En          (En),
      .Rw          (Rw),
      .Address_Bus (Address_Bus),
      .Data_Bus    (Data_Bus)
   );

   // ---------------- preload contents ----------------
   function automatic logic [7:0] init_val(input int i);
      case (i)
         1:       return 8'h61;
         2:       return 8'h01;
         3:       return 8'h02;
         7:       return 8'hFD;
         19:      return 8'h63;
         default: return 8'(i * 37 + 11);
      endcase
   endfunction

   // ---------------- bus-side memory ----------------
   logic [7:0] bus_mem [0:255];
   logic       loaded = 1'b0;
   logic       m_drv  = 1'b0;
   logic [7:0] m_q    = 8'h00;

   assign Data_Bus = m_drv ? m_q : 8'hzz;

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) bus_mem[i] <= init_val(i);
         loaded <= 1'b1;
      end else if (En && !Rw) begin
         bus_mem[Address_Bus] <= Data_Bus;
      end
      m_drv <= rst && En && Rw;
      m_q   <= bus_mem[Address_Bus];
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      bit         err;
      logic [7:0] rdata;
      int         acc;
      int         lat;
   } rsp_t;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
   } bus_t;

   logic [7:0] ref_mem [0:DEPTH-1];
   rsp_t       rsp_q [$];
   bus_t       bus_q [$];
   rsp_t       me;
   bus_t       mb;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic       en_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               me = rsp_q.pop_front();
               chk("rsp_err", 32'(rsp_err), 32'(me.err));
               chk("rsp_rdata", 32'(rsp_rdata), 32'(me.rdata));
               chk("rsp_latency", 32'(cyc - me.acc), 32'(me.lat));
            end
         end
         if (En) begin
            if (en_prev) chk("en_width", 32'd2, 32'd1);
            if (bus_q.size() == 0) begin
               chk("en_unexpected", 32'd1, 32'd0);
            end else begin
               mb = bus_q.pop_front();
               chk("bus_rw", 32'(Rw), 32'(!mb.wr));
               chk("bus_addr", 32'(Address_Bus), 32'(mb.addr));
               if (mb.wr) chk("bus_wdata", 32'(Data_Bus), 32'(mb.data));
            end
         end
         en_prev <= En;
      end else begin
         en_prev <= 1'b0;
      end
   end

   // ---------------- driver ----------------
   task automatic do_req(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                         output int acc, output int waits);
      rsp_t r;
      bus_t b;
      waits = 0;
      @(negedge clk);
      pause     = 1'b0;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = data;
      #1;
      while (!req_ready && waits < 50) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!req_ready) begin
         chk("req_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      if (32'(addr) >= DEPTH) begin
         r = '{err: 1'b1, rdata: 8'h00, acc: acc, lat: 1};
      end else if (wr) begin
         ref_mem[addr[5:0]] = data;
         r = '{err: 1'b0, rdata: 8'h00, acc: acc, lat: 1};
         b = '{wr: 1'b1, addr: addr, data: data};
         bus_q.push_back(b);
      end else begin
         r = '{err: 1'b0, rdata: ref_mem[addr[5:0]], acc: acc, lat: 2};
         b = '{wr: 1'b0, addr: addr, data: 8'h00};
         bus_q.push_back(b);
      end
      rsp_q.push_back(r);
      @(posedge clk);
   endtask

   task automatic idle_req();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (rsp_q.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      chk("drain_rsp", 32'(rsp_q.size()), 32'd0);
      chk("drain_bus", 32'(bus_q.size()), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int a1, a2, a3, wt, k;
      bit wr;
      logic [7:0] addr;

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_En", 32'(En), 32'd0);
      chk("rst_Rw", 32'(Rw), 32'd1);
      chk("rst_addr", 32'(Address_Bus), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      rst = 1'b1;

      // preloaded read
      do_req(1'b0, 8'd19, 8'h00, a1, wt);
      idle_req();
      wait_drain();

      // write then read back
      do_req(1'b1, 8'd4, 8'h5A, a1, wt);
      idle_req();
      do_req(1'b0, 8'd4, 8'h00, a1, wt);
      idle_req();
      wait_drain();

      // out-of-range reads
      do_req(1'b0, 8'h40, 8'h00, a1, wt);
      idle_req();
      do_req(1'b1, 8'hFF, 8'hAA, a1, wt);
      idle_req();
      wait_drain();

      // pause holds a pending request
      @(negedge clk);
      pause     = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'd5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("paused_ready", 32'(req_ready), 32'd0);
      end
      do_req(1'b0, 8'd5, 8'h00, a1, wt);
      chk("unpause_accept_waits", 32'(wt), 32'd0);
      // pause asserted during RD_REQ must not stop the read
      @(negedge clk);
      pause     = 1'b1;
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      pause = 1'b0;
      wait_drain();

      // reset during RD_WAIT
      do_req(1'b0, 8'd9, 8'h00, a1, wt);
      idle_req();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_En", 32'(En), 32'd0);
      chk("abort_Rw", 32'(Rw), 32'd1);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd0);
      rsp_q.delete();
      bus_q.delete();
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      rst = 1'b1;
      do_req(1'b0, 8'd1, 8'h00, a1, wt);
      idle_req();
      wait_drain();

      // back-to-back reads and writes
      do_req(1'b0, 8'd2, 8'h00, a1, wt);
      do_req(1'b0, 8'd3, 8'h00, a2, wt);
      do_req(1'b0, 8'd7, 8'h00, a3, wt);
      idle_req();
      chk("b2b_read_gap1", 32'(a2 - a1), 32'd3);
      chk("b2b_read_gap2", 32'(a3 - a2), 32'd3);
      wait_drain();
      do_req(1'b1, 8'd10, 8'h11, a1, wt);
      do_req(1'b1, 8'd11, 8'h22, a2, wt);
      idle_req();
      chk("b2b_write_gap", 32'(a2 - a1), 32'd2);
      wait_drain();

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255))
                                            : 8'($urandom_range(0, 63));
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            pause     = 1'b1;
            req_valid = 1'b1;
            k = $urandom_range(1, 4);
            repeat (k) @(negedge clk);
         end
         do_req(wr, addr, 8'($urandom), a1, wt);
         if ($urandom_range(0, 1) == 0) begin
            idle_req();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      idle_req();
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_sam_mem_bus_master
`default_nettype wire

// File: doc/sam_mem_bus_master.md
Name: sam_mem_bus_master

Overview:
- Bus-initiator side of the SAM memory interface (En / Rw / Address_Bus / Data_Bus).
- Converts a simple valid/ready request port into correctly timed memory read and write cycles, and returns read data on a response port.
- Masters the bidirectional Data_Bus during writes only; releases it to high-Z at all other times.
- Used by the program loader / console debug path; it is a second initiator on the same memory the Toplevel CPU uses.

Parameters:
- ADDR_W, 8, address bus width.
- DATA_W, 8, data bus width.
- MEM_DEPTH, 64, number of valid words; requests with addr >= MEM_DEPTH are rejected without a bus cycle.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- pause  in  1  hold off new requests; an in-flight transaction still completes.
- rsp_valid  out  1  one-cycle pulse: transaction finished.
- rsp_err  out  1  qualified by rsp_valid; address out of range.
- rsp_rdata  out  DATA_W  read data, qualified by rsp_valid; 0 for writes and errors.
- En  out  1  memory enable.
- Rw  out  1  1 = read, 0 = write.
- Address_Bus  out  ADDR_W  memory address.
- Data_Bus  inout  DATA_W  driven only in the WR state, otherwise high-Z.

Behaviour:
- Reset values (rst low, asynchronous):
  - state = IDLE; En = 0; Rw = 1; Address_Bus = 0; Data_Bus = high-Z.
  - req_ready = 0; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0.
- All bus outputs are registered.
- req_ready = (state == IDLE) && !pause && rst. It is combinational from state and pause.
- The memory samples En/Rw/Address_Bus at a rising edge and presents read data after that same edge.
- FSM states:
  - IDLE:
    - Accept a request. If addr >= MEM_DEPTH -> ERR.
    - Otherwise a write -> WR: drive En=1, Rw=0, Address_Bus=addr, Data_Bus=wdata.
    - Otherwise a read -> RD_REQ: drive En=1, Rw=1, Address_Bus=addr.
  - RD_REQ: one cycle. The memory captures the request at the exiting edge. Next state RD_WAIT; En <= 0, Rw stays 1.
  - RD_WAIT: one cycle. At the exiting edge, capture Data_Bus into rsp_rdata, pulse rsp_valid=1 with rsp_err=0, and go to IDLE.
  - WR: one cycle. The memory writes at the exiting edge. En <= 0, Rw <= 1, Data_Bus released; pulse rsp_valid=1 with rsp_rdata=0; go to IDLE.
  - ERR: one cycle with no bus activity. Pulse rsp_valid=1, rsp_err=1, rsp_rdata=0; go to IDLE.
- Latency, counted from the accept edge:
  - read: rsp_valid high 2 cycles after acceptance (the cycle after RD_WAIT).
  - write: 1 cycle.
  - error: 1 cycle.
- Back-to-back: req_ready returns in the same cycle that rsp_valid is high. Throughput is therefore one read per 3 cycles and one write per 2 cycles.
- Address_Bus holds its last value while idle. En=0 makes it don't-care.
- If Data_Bus is X or Z when captured in RD_WAIT, that value is passed through unmodified. There is no masking.
- pause:
  - Sampled only in IDLE. It has no effect on a transaction in progress.
  - A request held under pause stays pending and is not dropped.
- Reset mid-transaction: all outputs return to reset values immediately. There is no rsp_valid for the aborted transaction, and Data_Bus is released at once.
- Simultaneous rsp_valid and a new accept: allowed. The response belongs to the previous request.
- Address range check uses an unsigned compare of the full ADDR_W bits.

Decomposition:
- Package sam_bus_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, WR, ERR).
  - RW_READ = 1'b1, RW_WRITE = 1'b0.
  - default ADDR_W / DATA_W / MEM_DEPTH constants.
- One sub-module, sam_bus_tristate: registered output-enable plus data, driving Data_Bus or Z, and returning the sampled bus value.

Test Plan:
- Memory model preloaded with [19]=0x63, read addr 19 -> En=1,Rw=1,Address_Bus=0x13 for exactly 1 cycle; rsp_valid 2 cycles after accept with rsp_rdata=0x63, rsp_err=0.
- Write 0x5A to addr 4, then read addr 4 -> write rsp_valid 1 cycle after accept, Data_Bus=0x5A only during WR then Z; read returns 0x5A.
- Read addr 64 (0x40) -> no En pulse; rsp_valid 1 cycle after accept with rsp_err=1, rsp_rdata=0.
- pause=1 with req_valid=1 for 5 cycles -> req_ready=0, no En; deassert pause -> accepted on next edge. Assert pause during RD_REQ -> read still completes.
- rst low during RD_WAIT -> En=0, Rw=1, Data_Bus=Z immediately; no rsp_valid; after release, read addr 1 returns 0x61.
- Back-to-back reads of addr 2,3,7 with req_valid held -> rsp_rdata 0x01, 0x02, 0xFD on responses 3 cycles apart.
